// File: rtl/sprite_addr_cal.sv
// -----------------------------------------------------------------------------
// sprite_addr_cal
//
// Per-sprite pixel-address generator for the sprite display path. Each cycle
// it takes one sprite's pattern descriptor, its placement/attribute word and
// the current scan position. It reports whether that position lies inside the
// visible sprite and, if it does, the linear pixel index into the sprite ROM.
// The result is registered, so it appears one cycle after the inputs.
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset (clears both outputs)
//   pattern_info  [79:64] base index, [63:48] width, [47:32] height,
//                 [31:16] row stride, [15:0] reserved
//   sprite_info   [31] visible, [30] horizontal flip, [29:20] x origin,
//                 [19:10] y origin, [9:0] reserved
//   hcount        current pixel column
//   vcount        current pixel row
//   addr_output   pixel index into the sprite ROM (0 when not a hit)
//   valid         current pixel belongs to this sprite
// -----------------------------------------------------------------------------
module sprite_addr_cal #(
  parameter int ADDR_W = 16,
  parameter int POS_W  = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [5*ADDR_W-1:0]   pattern_info,
  input  logic [31:0]           sprite_info,
  input  logic [POS_W-1:0]      hcount,
  input  logic [POS_W-1:0]      vcount,
  output logic [ADDR_W-1:0]     addr_output,
  output logic                  valid
);

  // One bit wider than the widest operand so origin + size can never wrap.
  localparam int CMP_W = ((ADDR_W > POS_W) ? ADDR_W : POS_W) + 1;

  logic [ADDR_W-1:0] w_base, w_width, w_height, w_stride;
  logic              w_visible, w_flip;
  logic [POS_W-1:0]  w_x, w_y;

  assign w_base    = pattern_info[4*ADDR_W +: ADDR_W];
  assign w_width   = pattern_info[3*ADDR_W +: ADDR_W];
  assign w_height  = pattern_info[2*ADDR_W +: ADDR_W];
  assign w_stride  = pattern_info[1*ADDR_W +: ADDR_W];
  assign w_visible = sprite_info[31];
  assign w_flip    = sprite_info[30];
  assign w_x       = sprite_info[20 +: POS_W];
  assign w_y       = sprite_info[10 +: POS_W];

  logic [CMP_W-1:0] w_h, w_v, w_x_ext, w_y_ext, w_x_end, w_y_end;
  logic [CMP_W-1:0] w_dx, w_dy;
  logic [31:0]      w_col, w_addr;
  logic             w_hit;

  // NOTE: purely combinational logic uses always_comb with every output
  // assigned on every path, so no latch can be inferred.
  always_comb begin
    w_h     = CMP_W'(hcount);
    w_v     = CMP_W'(vcount);
    w_x_ext = CMP_W'(w_x);
    w_y_ext = CMP_W'(w_y);
    w_x_end = w_x_ext + CMP_W'(w_width);
    w_y_end = w_y_ext + CMP_W'(w_height);

    // A zero width or height makes the half-open range empty, so no hit.
    w_hit = w_visible
          && (w_h >= w_x_ext) && (w_h < w_x_end)
          && (w_v >= w_y_ext) && (w_v < w_y_end);

    // Offsets are only meaningful on a hit; otherwise the address is masked.
    w_dx = w_h - w_x_ext;
    w_dy = w_v - w_y_ext;

    if (w_flip) begin
      w_col = 32'(w_width) - 32'd1 - 32'(w_dx);
    end else begin
      w_col = 32'(w_dx);
    end

    // Full-width arithmetic; the ROM index wraps modulo 2**ADDR_W on truncation.
    w_addr = 32'(w_base) + 32'(w_dy) * 32'(w_stride) + w_col;
  end

  logic [ADDR_W-1:0] r_addr;
  logic              r_valid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_hit;
      r_addr  <= w_hit ? w_addr[ADDR_W-1:0] : '0;
    end
  end

  assign addr_output = r_addr;
  assign valid       = r_valid;

  // Reserved descriptor fields and the high address bits are intentionally dropped.
  logic w_unused;
  assign w_unused = &{1'b0, pattern_info[ADDR_W-1:0], sprite_info[9:0],
                      w_addr[31:ADDR_W]};

endmodule

// File: tb/tb_sprite_addr_cal.sv
module tb_sprite_addr_cal;

  logic        clk = 1'b0;
  logic        reset;
  logic [79:0] pattern_info;
  logic [31:0] sprite_info;
  logic [9:0]  hcount, vcount;
  logic [15:0] addr_output;
  logic        valid;

  int n_checks = 0;
  int n_pass   = 0;

  sprite_addr_cal dut (
    .clk          (clk),
    .reset        (reset),
    .pattern_info (pattern_info),
    .sprite_info  (sprite_info),
    .hcount       (hcount),
    .vcount       (vcount),
    .addr_output  (addr_output),
    .valid        (valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [79:0] pat(input int base, input int w, input int h, input int st);
    return {16'(base), 16'(w), 16'(h), 16'(st), 16'h0000};
  endfunction

  function automatic logic [31:0] spr(input bit vis, input bit flip, input int x, input int y);
    return {vis, flip, 10'(x), 10'(y), 10'h000};
  endfunction

  // Reference: plain integer arithmetic straight from the hit/address rules.
  function automatic void model(input logic [79:0] p, input logic [31:0] s,
                                input int h, input int v,
                                output bit hit, output int unsigned addr);
    longint base, w, ht, st, x, y, col;
    base = p[79:64]; w = p[63:48]; ht = p[47:32]; st = p[31:16];
    x = s[29:20]; y = s[19:10];
    hit = s[31] && (h >= x) && (h < x + w) && (v >= y) && (v < y + ht);
    col = s[30] ? (w - 1 - (h - x)) : (h - x);
    addr = hit ? int'((base + (v - y) * st + col) % 65536) : 0;
  endfunction

  // Drive one set of inputs between edges and wait for the registered result.
  task automatic step(input logic [79:0] p, input logic [31:0] s, input int h, input int v);
    @(negedge clk);
    pattern_info = p;
    sprite_info  = s;
    hcount       = 10'(h);
    vcount       = 10'(v);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input bit exp_v, input int exp_a);
    check({tag, ".valid"}, 32'(valid), 32'(exp_v));
    check({tag, ".addr"},  32'(addr_output), 32'(exp_a));
  endtask

  logic [79:0] p_std, p_flipless;
  logic [31:0] s_std, s_flip;

  initial begin
    bit          m_hit;
    int unsigned m_addr;

    reset        = 1'b1;
    pattern_info = '0;
    sprite_info  = '0;
    hcount       = '0;
    vcount       = '0;
    p_std        = pat(1792, 16, 32, 16);
    s_std        = spr(1'b1, 1'b0, 100, 200);
    s_flip       = spr(1'b1, 1'b1, 100, 200);
    p_flipless   = pat(1792, 0, 32, 16);

    // Hit inputs present while reset is held: outputs must stay cleared.
    @(negedge clk);
    pattern_info = p_std; sprite_info = s_std; hcount = 10'd100; vcount = 10'd200;
    @(posedge clk); #1;
    expect_out("reset_hold", 1'b0, 0);
    @(negedge clk);
    reset = 1'b0;

    // Corners and edges of the 16x32 sprite at (100,200).
    step(p_std, s_std, 100, 200); expect_out("corner_tl", 1'b1, 1792);
    step(p_std, s_std, 115, 231); expect_out("corner_br", 1'b1, 2303);
    step(p_std, s_std, 116, 200); expect_out("edge_right", 1'b0, 0);
    step(p_std, s_std,  99, 200); expect_out("edge_left", 1'b0, 0);
    step(p_std, s_std, 100, 232); expect_out("edge_bottom", 1'b0, 0);
    step(p_std, s_std, 100, 199); expect_out("edge_top", 1'b0, 0);

    // Horizontal flip.
    step(p_std, s_flip, 100, 200); expect_out("flip_l", 1'b1, 1807);
    step(p_std, s_flip, 115, 200); expect_out("flip_r", 1'b1, 1792);
    step(p_std, s_flip, 100, 201); expect_out("flip_row1", 1'b1, 1823);

    // Visibility cleared right after a hit, then a zero-width descriptor.
    step(p_std, s_std, 105, 210); expect_out("vis_on", 1'b1, 1792 + 10 * 16 + 5);
    step(p_std, spr(1'b0, 1'b0, 100, 200), 105, 210); expect_out("vis_off", 1'b0, 0);
    step(p_flipless, s_std, 100, 200); expect_out("zero_width", 1'b0, 0);
    step(pat(1792, 16, 0, 16), s_std, 100, 200); expect_out("zero_height", 1'b0, 0);

    // Address wrap and right-edge overflow of x+width.
    step(pat(65535, 16, 32, 16), spr(1'b1, 1'b0, 0, 0), 1, 0); expect_out("addr_wrap", 1'b1, 0);
    step(pat(1792, 16, 32, 16), spr(1'b1, 1'b0, 1010, 200), 1023, 200);
    expect_out("x_overflow", 1'b1, 1792 + 13);

    // Asynchronous reset between edges clears outputs immediately.
    step(p_std, s_std, 101, 202); expect_out("pre_reset", 1'b1, 1792 + 2 * 16 + 1);
    #2;
    reset = 1'b1;
    #1;
    expect_out("async_reset", 1'b0, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    expect_out("post_reset", 1'b1, 1792 + 2 * 16 + 1);

    // Randomized descriptors and scan positions near the sprite.
    for (int i = 0; i < 300; i++) begin
      logic [79:0] p;
      logic [31:0] s;
      int x, y, h, v;
      x = int'($urandom_range(0, 1023));
      y = int'($urandom_range(0, 1023));
      p = pat(int'($urandom_range(0, 65535)), int'($urandom_range(0, 20)),
              int'($urandom_range(0, 20)),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535))
                                          : int'($urandom_range(0, 64)));
      p[15:0] = 16'($urandom);
      s = spr(($urandom_range(0, 9) != 0), 1'($urandom), x, y);
      s[9:0] = 10'($urandom);
      h = (x + int'($urandom_range(0, 24)) - 2) & 1023;
      v = (y + int'($urandom_range(0, 24)) - 2) & 1023;
      model(p, s, h, v, m_hit, m_addr);
      step(p, s, h, v);
      expect_out($sformatf("rand%0d", i), m_hit, int'(m_addr));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
